// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a 2**AW-entry FIFO array: write/read pointers with wrap bit,
// gated array enables, full/empty/threshold status and sticky error flags. Optional fifo_count via FIFO_OCCUPANCY_EN.
module fifo_ctrl #(
  parameter int AW     = 4,
  parameter int THRESH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic          rd,
  input  logic          clr_err,
  output logic          fifo_we,
  output logic          fifo_rd,
  output logic [AW:0]   wptr,
  output logic [AW:0]   rptr,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic          fifo_threshold,
  output logic          fifo_overflow,
  output logic          fifo_underflow
`ifdef FIFO_OCCUPANCY_EN
  ,
  output logic [AW:0]   fifo_count
`endif
);

  localparam logic [AW:0] THRESH_V = (AW+1)'(THRESH);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        r_overflow;
  logic        r_underflow;

  logic [AW:0] w_occ;
  logic        w_full;
  logic        w_empty;
  logic        w_we;
  logic        w_rd;

  // Pointers are one bit wider than the address so equal addresses can be told apart as full vs empty.
  assign w_occ   = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_we    = wr & ~w_full;
  assign w_rd    = rd & ~w_empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_we) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  // A new error in the same cycle as clr_err wins, so the flag is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr & w_full)  r_overflow  <= 1'b1;
      else if (clr_err) r_overflow  <= 1'b0;
      if (rd & w_empty) r_underflow <= 1'b1;
      else if (clr_err) r_underflow <= 1'b0;
    end
  end

`ifdef FIFO_OCCUPANCY_EN
  logic [AW:0] r_count;
  logic [AW:0] w_count_nxt;

  // NOTE: combinational blocks assign a default first so no latch is inferred.
  always_comb begin
    w_count_nxt = r_count;
    if (w_we && !w_rd)      w_count_nxt = r_count + 1'b1;
    else if (w_rd && !w_we) w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_count <= '0;
    else     r_count <= w_count_nxt;
  end

  assign fifo_count = r_count;
`endif

  assign fifo_we        = w_we;
  assign fifo_rd        = w_rd;
  assign wptr           = r_wptr;
  assign rptr           = r_rptr;
  assign fifo_full      = w_full;
  assign fifo_empty     = w_empty;
  assign fifo_threshold = (w_occ >= THRESH_V);
  assign fifo_overflow  = r_overflow;
  assign fifo_underflow = r_underflow;

endmodule
